// File: rtl/regfile_read_arbiter.sv
// rtl/regfile_read_arbiter.sv - round-robin arbiter sharing register file read ports among operand requesters
module regfile_read_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int NUM_PORTS = 2,
    parameter int TAG_W     = 6,
    parameter int DATA_W    = 32
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              flush,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ-1:0][TAG_W-1:0]     req_tag,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic [NUM_PORTS-1:0][TAG_W-1:0]   rf_read_tags,
    input  logic [NUM_PORTS-1:0][DATA_W-1:0]  rf_read_data,
    output logic [NUM_REQ-1:0]                rsp_valid,
    output logic [NUM_REQ-1:0][DATA_W-1:0]    rsp_data,
    output logic [15:0]                       stall_count
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]                ptr;
    logic [PTR_W-1:0]                last_idx;
    logic [PTR_W-1:0]                ptr_next;
    logic [NUM_REQ-1:0]              grant;
    logic [NUM_REQ-1:0][DATA_W-1:0]  grant_data;
    logic                            port_used;
    logic                            stall_evt;

    // Tag 0 is the hardwired zero register: granted for free without a port.
    always_comb begin
        int               used;
        logic [PTR_W:0]   sum;
        logic [PTR_W-1:0] idx;
        grant        = '0;
        grant_data   = '0;
        rf_read_tags = '0;
        last_idx     = ptr;
        port_used    = 1'b0;
        used         = 0;
        sum          = '0;
        idx          = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NUM_REQ))
                sum = sum - (PTR_W+1)'(NUM_REQ);
            idx = sum[PTR_W-1:0];
            if (req_valid[idx]) begin
                if (req_tag[idx] == '0) begin
                    grant[idx] = 1'b1;
                end else if (used < NUM_PORTS) begin
                    grant[idx] = 1'b1;
                    for (int p = 0; p < NUM_PORTS; p++) begin
                        if (used == p) begin
                            rf_read_tags[p] = req_tag[idx];
                            grant_data[idx] = rf_read_data[p];
                        end
                    end
                    used      = used + 1;
                    last_idx  = idx;
                    port_used = 1'b1;
                end
            end
        end
        if (flush) begin
            grant        = '0;
            rf_read_tags = '0;
        end
    end

    assign req_ready = grant;
    assign ptr_next  = (last_idx == PTR_W'(NUM_REQ - 1)) ? '0 : last_idx + 1'b1;
    assign stall_evt = !flush && |(req_valid & ~grant);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr         <= '0;
            rsp_valid   <= '0;
            rsp_data    <= '0;
            stall_count <= '0;
        end else begin
            rsp_valid <= grant;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i])
                    rsp_data[i] <= grant_data[i];
            end
            if (!flush && port_used)
                ptr <= ptr_next;
            if (stall_evt && stall_count != 16'hFFFF)
                stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// tb/tb_regfile_read_arbiter.sv - directed scoreboard bench for regfile_read_arbiter
module tb_regfile_read_arbiter;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic                 flush = 1'b0;
    logic [3:0]           req_valid = '0;
    logic [3:0][5:0]      req_tag = '0;
    logic [3:0]           req_ready;
    logic [1:0][5:0]      rf_read_tags;
    logic [1:0][31:0]     rf_read_data;
    logic [3:0]           rsp_valid;
    logic [3:0][31:0]     rsp_data;
    logic [15:0]          stall_count;

    typedef struct {
        logic [3:0]       v;
        logic [3:0][31:0] d;
    } rsp_t;

    rsp_t             sb[$];
    logic [3:0][31:0] model_data = '0;
    int               passed = 0;
    int               failed = 0;
    int               total = 0;
    logic [3:0]       seen;

    regfile_read_arbiter dut (
        .clock        (clock),
        .reset        (reset),
        .flush        (flush),
        .req_valid    (req_valid),
        .req_tag      (req_tag),
        .req_ready    (req_ready),
        .rf_read_tags (rf_read_tags),
        .rf_read_data (rf_read_data),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .stall_count  (stall_count)
    );

    always #5 clock = ~clock;

    // Register file model: register n holds n * 0x11.
    always_comb begin
        for (int p = 0; p < 2; p++)
            rf_read_data[p] = 32'(rf_read_tags[p]) * 32'd17;
    end

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else begin
            failed = failed + 1;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic step(input logic [3:0] v, input logic [3:0][5:0] t, input logic fl,
                        input logic [3:0] er, input logic [5:0] et0, input logic [5:0] et1,
                        input logic [15:0] es, input logic [1:0] ep);
        rsp_t e;
        req_valid = v;
        req_tag   = t;
        flush     = fl;
        #1;
        chk("req_ready", 128'(req_ready), 128'(er));
        chk("rf_read_tags", 128'(rf_read_tags), 128'({et1, et0}));
        for (int i = 0; i < 4; i++)
            if (er[i]) model_data[i] = 32'(t[i]) * 32'd17;
        e.v = er;
        e.d = model_data;
        sb.push_back(e);
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 128'(1), 128'(0));
        end else begin
            e = sb.pop_front();
            chk("rsp_valid", 128'(rsp_valid), 128'(e.v));
            chk("rsp_data", 128'(rsp_data), 128'(e.d));
        end
        chk("stall_count", 128'(stall_count), 128'(es));
        chk("ptr", 128'(dut.ptr), 128'(ep));
        @(negedge clock);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        #1;
        chk("reset_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("reset_rsp_data", 128'(rsp_data), 128'(0));
        chk("reset_stall", 128'(stall_count), 128'(0));
        chk("reset_ptr", 128'(dut.ptr), 128'(0));
        chk("reset_ready", 128'(req_ready), 128'(0));
        @(negedge clock);
        reset = 1'b1;

        // all four valid from ptr=0
        step(4'b1111, {6'd8, 6'd7, 6'd6, 6'd5}, 1'b0, 4'b0011, 6'd5, 6'd6, 16'd1, 2'd2);
        // the two denied requesters follow on ports 0 and 1
        step(4'b1100, {6'd8, 6'd7, 6'd0, 6'd0}, 1'b0, 4'b1100, 6'd7, 6'd8, 16'd1, 2'd0);
        // requester 1 reads tag 0 and consumes no port
        step(4'b1111, {6'd11, 6'd10, 6'd0, 6'd9}, 1'b0, 4'b0111, 6'd9, 6'd10, 16'd2, 2'd3);
        // flush cancels grants, no response, ptr holds
        step(4'b1111, {6'd4, 6'd3, 6'd2, 6'd1}, 1'b1, 4'b0000, 6'd0, 6'd0, 16'd2, 2'd3);
        // wrap-around scan from ptr=3
        step(4'b1111, {6'd4, 6'd3, 6'd2, 6'd1}, 1'b0, 4'b1001, 6'd4, 6'd1, 16'd3, 2'd1);
        // idle cycle
        step(4'b0000, {6'd4, 6'd3, 6'd2, 6'd1}, 1'b0, 4'b0000, 6'd0, 6'd0, 16'd3, 2'd1);
        // single request behind ptr: unused port drives tag 0
        step(4'b0001, {6'd0, 6'd0, 6'd0, 6'd2}, 1'b0, 4'b0001, 6'd2, 6'd0, 16'd3, 2'd1);

        // sustained contention: fairness over two cycles, then saturation
        req_valid = 4'b1111;
        req_tag   = {6'd4, 6'd3, 6'd2, 6'd1};
        seen      = '0;
        for (int c = 0; c < 70000; c++) begin
            #1;
            if (c < 2) seen = seen | req_ready;
            @(posedge clock);
            @(negedge clock);
        end
        chk("fairness_two_cycles", 128'(seen), 128'(4'b1111));
        chk("stall_saturated", 128'(stall_count), 128'(16'hFFFF));
        for (int i = 0; i < 4; i++) model_data[i] = 32'(i + 1) * 32'd17;

        // 70000 cycles of two grants each from ptr=1 leave ptr at 1
        step(4'b0011, {6'd0, 6'd0, 6'd2, 6'd1}, 1'b0, 4'b0011, 6'd2, 6'd1, 16'hFFFF, 2'd1);
        chk("pre_reset_rsp_valid", 128'(rsp_valid), 128'(4'b0011));
        reset = 1'b0;
        #1;
        chk("async_reset_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("async_reset_rsp_data", 128'(rsp_data), 128'(0));
        chk("async_reset_stall", 128'(stall_count), 128'(0));
        chk("async_reset_ptr", 128'(dut.ptr), 128'(0));
        model_data = '0;
        @(negedge clock);
        reset = 1'b1;
        step(4'b1111, {6'd8, 6'd7, 6'd6, 6'd5}, 1'b0, 4'b0011, 6'd5, 6'd6, 16'd1, 2'd2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
